// File: rtl/alu_result_writeback.sv
// ALU write-back: updates the active-low operand registers and writes the result to the register-board bus one byte at a time.
// Latency: the operand registers update on the accept edge, and bus_req rises on the cycle after accept.
// Backpressure: res_ready is low while a byte is pending. Each byte waits for bus_ack, up to WB_TIMEOUT cycles.
module alu_result_writeback #(
    parameter int WB_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [15:0] res_data,
    input  logic [1:0]  res_mode,
    input  logic        res_push_op,
    output logic [7:0]  notOP,
    output logic [7:0]  notOPold,
    output logic        bus_req,
    output logic [7:0]  bus_data,
    output logic        bus_hi,
    input  logic        bus_ack,
    output logic        wb_error,
    input  logic        err_clr,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

    localparam logic [7:0] TO_LAST = 8'(WB_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [15:0] cap_data;
    logic [1:0]  cap_mode;
    logic [7:0]  tcnt, tcnt_nxt;
    logic        err_set;
    logic        accept;

    assign res_ready = (state == IDLE);
    assign busy      = !res_ready;
    assign accept    = res_valid && res_ready;

    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        err_set   = 1'b0;
        bus_req   = 1'b0;
        bus_data  = 8'h00;
        bus_hi    = 1'b0;
        case (state)
            IDLE: begin
                tcnt_nxt = 8'd0;
                if (accept) begin
                    case (res_mode)
                        2'b00:   state_nxt = IDLE;
                        2'b10:   state_nxt = WR_HI;
                        default: state_nxt = WR_LO;
                    endcase
                end
            end
            WR_LO, WR_HI: begin
                bus_req  = 1'b1;
                bus_hi   = (state == WR_HI);
                bus_data = (state == WR_HI) ? cap_data[15:8] : cap_data[7:0];
                // An ack on the final permitted cycle takes priority over the timeout.
                if (bus_ack) begin
                    tcnt_nxt  = 8'd0;
                    state_nxt = (state == WR_LO && cap_mode == 2'b11) ? WR_HI : IDLE;
                end else if (tcnt == TO_LAST) begin
                    tcnt_nxt  = 8'd0;
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tcnt_nxt = tcnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tcnt     <= 8'd0;
            cap_data <= 16'h0000;
            cap_mode <= 2'b00;
            notOP    <= 8'hFF;
            notOPold <= 8'hFF;
            wb_error <= 1'b0;
        end else begin
            state <= state_nxt;
            tcnt  <= tcnt_nxt;
            if (accept) begin
                cap_data <= res_data;
                cap_mode <= res_mode;
                if (res_push_op) begin
                    notOPold <= notOP;
                    notOP    <= ~res_data[7:0];
                end
            end
            if (err_set)
                wb_error <= 1'b1;
            else if (err_clr)
                wb_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_result_writeback.sv
// Directed bench for alu_result_writeback. A scoreboard queue holds the expected bus bytes, and an operand model tracks notOP/notOPold.
module tb_alu_result_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [1:0]  res_mode;
    logic        res_push_op;
    logic [7:0]  notOP;
    logic [7:0]  notOPold;
    logic        bus_req;
    logic [7:0]  bus_data;
    logic        bus_hi;
    logic        bus_ack;
    logic        wb_error;
    logic        err_clr;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    logic [8:0] sb[$];
    logic [7:0] m_op = 8'hFF;
    logic [7:0] m_old = 8'hFF;

    alu_result_writeback #(.WB_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_mode(res_mode), .res_push_op(res_push_op),
        .notOP(notOP), .notOPold(notOPold),
        .bus_req(bus_req), .bus_data(bus_data), .bus_hi(bus_hi), .bus_ack(bus_ack),
        .wb_error(wb_error), .err_clr(err_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one result in IDLE and updates the models on the accept edge.
    task automatic offer(input logic [15:0] d, input logic [1:0] m, input logic p, input logic track);
        res_valid   = 1'b1;
        res_data    = d;
        res_mode    = m;
        res_push_op = p;
        tick();
        res_valid = 1'b0;
        if (p) begin
            m_old = m_op;
            m_op  = ~d[7:0];
        end
        if (track && m[0]) sb.push_back({1'b0, d[7:0]});
        if (track && m[1]) sb.push_back({1'b1, d[15:8]});
    endtask

    // Returns bus_ack after `delay` request cycles for each byte and checks each byte against the scoreboard.
    task automatic serve(input int delay, input int budget);
        int waited = 0;
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            if (bus_req) begin
                chk("bus_data", {8'h00, bus_data}, {8'h00, sb[0][7:0]});
                chk("bus_hi", {15'h0, bus_hi}, {15'h0, sb[0][8]});
                if (waited == delay) begin
                    bus_ack = 1'b1;
                    void'(sb.pop_front());
                    waited = 0;
                end else begin
                    waited++;
                end
            end
            tick();
            bus_ack = 1'b0;
            n++;
        end
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $error("FAIL serve_timeout observed=%0d pending expected=0 pending", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int cnt;
        rst = 1'b1; res_valid = 1'b0; res_data = 16'h0; res_mode = 2'b00;
        res_push_op = 1'b0; bus_ack = 1'b0; err_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_notOP", {8'h0, notOP}, 16'h00FF);
        chk("rst_notOPold", {8'h0, notOPold}, 16'h00FF);
        chk("rst_bus_req", {15'h0, bus_req}, 16'h0);
        chk("rst_bus_data", {8'h0, bus_data}, 16'h0);
        chk("rst_bus_hi", {15'h0, bus_hi}, 16'h0);
        chk("rst_ready", {15'h0, res_ready}, 16'h1);
        chk("rst_busy", {15'h0, busy}, 16'h0);
        chk("rst_wb_error", {15'h0, wb_error}, 16'h0);

        // Mode 00 push: operands only, no bus activity.
        offer(16'h12A5, 2'b00, 1'b1, 1'b1);
        chk("m00_notOP", {8'h0, notOP}, {8'h0, m_op});
        chk("m00_notOP_const", {8'h0, notOP}, 16'h005A);
        chk("m00_notOPold", {8'h0, notOPold}, 16'h00FF);
        chk("m00_bus_req", {15'h0, bus_req}, 16'h0);
        chk("m00_ready", {15'h0, res_ready}, 16'h1);

        // Back-to-back mode 00 accepts.
        offer(16'h00C3, 2'b00, 1'b1, 1'b1);
        offer(16'h0081, 2'b00, 1'b1, 1'b1);
        chk("b2b_notOP", {8'h0, notOP}, 16'h007E);
        chk("b2b_notOPold", {8'h0, notOPold}, 16'h003C);
        chk("b2b_model", {notOP, notOPold}, {m_op, m_old});

        // Two-byte write, with each ack returned 2 cycles after the request.
        offer(16'hBEEF, 2'b11, 1'b0, 1'b1);
        chk("m11_bus_req", {15'h0, bus_req}, 16'h1);
        chk("m11_busy", {15'h0, busy}, 16'h1);
        serve(2, 40);
        chk("m11_busy_done", {15'h0, busy}, 16'h0);
        chk("m11_ready_done", {15'h0, res_ready}, 16'h1);
        chk("m11_wb_error", {15'h0, wb_error}, 16'h0);
        chk("m11_operands", {notOP, notOPold}, {m_op, m_old});

        // High-byte write with no ack, so the transfer times out.
        offer(16'h3400, 2'b10, 1'b0, 1'b0);
        chk("to_bus_data", {8'h0, bus_data}, 16'h0034);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (!bus_req) break;
            cnt++;
            tick();
        end
        chk("to_req_cycles", 16'(cnt), 16'd4);
        chk("to_wb_error", {15'h0, wb_error}, 16'h1);
        chk("to_idle", {15'h0, res_ready}, 16'h1);
        chk("to_operands", {notOP, notOPold}, {m_op, m_old});
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", {15'h0, wb_error}, 16'h0);

        // A timeout coinciding with err_clr still sets wb_error.
        offer(16'h0055, 2'b01, 1'b0, 1'b0);
        err_clr = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (!bus_req) break;
            cnt++;
            tick();
        end
        chk("set_wins_cycles", 16'(cnt), 16'd4);
        chk("set_wins", {15'h0, wb_error}, 16'h1);
        tick();
        err_clr = 1'b0;
        chk("clr_after_set", {15'h0, wb_error}, 16'h0);

        // An ack on the 4th WR cycle beats the timeout.
        offer(16'h7788, 2'b01, 1'b1, 1'b1);
        serve(3, 20);
        chk("ack_wins_err", {15'h0, wb_error}, 16'h0);
        chk("ack_wins_busy", {15'h0, busy}, 16'h0);
        chk("ack_wins_operands", {notOP, notOPold}, {m_op, m_old});

        // Reset asserted during WR_HI aborts the transfer.
        offer(16'h1122, 2'b11, 1'b1, 1'b0);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("rst_mid_in_hi", {15'h0, bus_hi}, 16'h1);
        chk("rst_mid_data", {8'h0, bus_data}, 16'h0011);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_op = 8'hFF; m_old = 8'hFF;
        chk("rst_mid_bus_req", {15'h0, bus_req}, 16'h0);
        chk("rst_mid_operands", {notOP, notOPold}, {m_op, m_old});
        chk("rst_mid_ready", {15'h0, res_ready}, 16'h1);
        chk("rst_mid_wb_error", {15'h0, wb_error}, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_result_writeback.md
Name: alu_result_writeback

Overview:
- Write-back end of the ALU operand path.
- Takes a 16-bit ALU result and maintains the active-low operand registers notOP and notOPold that feed the ALU input selector.
- Drives the result onto the 8-bit register-board bus one byte at a time, using a req/ack handshake.
- Sits on the register board next to the ALU input selector, which keeps the byte-wide cable count low.

Parameters:
- WB_TIMEOUT, 15: maximum cycles a byte waits for bus_ack before the transfer is abandoned; legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous reset, active-high
- res_valid  input  1  ALU result offered
- res_ready  output  1  block can accept a result
- res_data  input  16  ALU result; [7:0] is the low byte, [15:8] the high byte
- res_mode  input  2  00 = no bus write, 01 = low byte only, 10 = high byte only, 11 = low byte then high byte
- res_push_op  input  1  load res_data[7:0] into the operand register
- notOP  output  8  current operand, active-low
- notOPold  output  8  previous operand, active-low
- bus_req  output  1  byte write request
- bus_data  output  8  byte being written
- bus_hi  output  1  0 = low byte, 1 = high byte
- bus_ack  input  1  bus accepted the byte
- wb_error  output  1  sticky timeout flag
- err_clr  input  1  clears wb_error
- busy  output  1  a write is in progress (state is not IDLE)

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values:
  - notOP = 8'hFF and notOPold = 8'hFF (operand value 0)
  - bus_req = 0, bus_data = 8'h00, bus_hi = 0
  - res_ready = 1, busy = 0, wb_error = 0
  - state = IDLE, timeout counter = 0
- rst asserted mid-transfer aborts the transfer immediately; no partial byte is completed.
- States: IDLE, WR_LO, WR_HI.
- res_ready = (state == IDLE). busy = !res_ready.
- Accept = res_valid && res_ready on a rising edge. On accept:
  - res_data and res_mode are captured.
  - If res_push_op = 1, on the same edge: notOPold <= notOP, notOP <= ~res_data[7:0].
  - If res_push_op = 0, neither operand register changes.
- State transitions on accept:
  - mode 00: stay in IDLE; res_ready stays 1, so back-to-back accepts every cycle are legal.
  - mode 01 or 11: go to WR_LO.
  - mode 10: go to WR_HI.
- Latency: bus_req rises on the cycle after accept.
- In WR_LO and WR_HI:
  - bus_req = 1.
  - bus_data = the captured byte for the state ([7:0] in WR_LO, [15:8] in WR_HI).
  - bus_hi = 1 in WR_HI, 0 in WR_LO.
  - bus_data and bus_hi stay stable until bus_ack is sampled high.
- On bus_ack high:
  - From WR_LO: go to WR_HI if mode = 11, else to IDLE.
  - From WR_HI: go to IDLE.
  - A 2-byte write therefore needs at least 2 bus cycles.
- Outside WR states: bus_req = 0, bus_data = 8'h00, bus_hi = 0. bus_ack sampled in IDLE is ignored.
- Timeout:
  - An 8-bit counter clears on entry to each WR state.
  - It increments on each WR cycle in which bus_ack is low.
  - If bus_ack is low on a cycle where the counter equals WB_TIMEOUT-1: set wb_error, go to IDLE, and drop any remaining byte.
  - If bus_ack is high on that same cycle, the ack wins: normal transition, no error.
- wb_error:
  - Cleared by err_clr on the next edge.
  - If a timeout and err_clr occur on the same cycle, the set wins.
  - wb_error does not block new accepts.
- Operand registers change only on accept with res_push_op = 1. They are unaffected by a timeout or by bus activity.

Test Plan:
- Reset, then push 16'h12A5 with mode 00 and push_op = 1:
  - required: notOP = 8'h5A, notOPold = 8'hFF the cycle after accept
  - required: bus_req stays 0 and res_ready stays 1
- Push 16'h00C3 and then 16'h0081, mode 00, push_op = 1, back to back:
  - required: notOP = 8'h7E, notOPold = 8'h3C
- Mode 11, res_data = 16'hBEEF, bus_ack returned 2 cycles after each request:
  - required: bus_data = 8'hEF with bus_hi = 0, then bus_data = 8'hBE with bus_hi = 1
  - required: busy falls after the second ack and res_ready = 1 the next cycle
- Mode 10, res_data = 16'h3400, WB_TIMEOUT = 4, bus_ack never returned:
  - required: bus_req high for exactly 4 cycles, then wb_error = 1 and state IDLE
  - then err_clr = 1 for one cycle: required wb_error = 0
- Mode 01, WB_TIMEOUT = 4, bus_ack first returned on the 4th WR cycle:
  - required: transfer completes and wb_error stays 0 (ack beats timeout)
- Mode 11, rst asserted during WR_HI:
  - required: next cycle bus_req = 0, notOP = notOPold = 8'hFF, res_ready = 1, wb_error = 0
